// File: rtl/button_bounce_gen.sv
// Push-button emulator: turns a clean level command into a bouncing raw line (LFSR-timed glitches) then a stable hold.
// Accept-to-settled latency is the sum of segment lengths plus SETTLE_CYCLES; commands are refused (cmd_ready low) while busy.
module button_bounce_gen #(
    parameter int          N_BOUNCES     = 4,
    parameter int          MAX_SEG       = 8,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_level,
    output logic cmd_ready,
    output logic button_out,
    output logic settled,
    output logic busy
);

    localparam int SEG_W = $clog2(MAX_SEG + 1);
    localparam int TOG_W = $clog2(2 * N_BOUNCES + 2);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [15:0]      SEG_MASK    = 16'(MAX_SEG - 1);
    localparam logic [TOG_W-1:0] TOG_TOTAL   = TOG_W'(2 * N_BOUNCES);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES);
    localparam bit               HAS_BOUNCE  = (N_BOUNCES > 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BOUNCE = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [SEG_W-1:0] seg_cnt_q, seg_cnt_d;
    logic [TOG_W-1:0] tog_cnt_q, tog_cnt_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic             button_out_q, button_out_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             settled_q, settled_d;
    logic             busy_q, busy_d;
    logic [SEG_W-1:0] seg_len;

    always_comb begin
        state_d      = state_q;
        seg_cnt_d    = seg_cnt_q;
        tog_cnt_d    = tog_cnt_q;
        settle_cnt_d = settle_cnt_q;
        button_out_d = button_out_q;
        cmd_ready_d  = cmd_ready_q;
        settled_d    = 1'b0;
        // Fibonacci taps 16,14,13,11 free-run every cycle so segment lengths vary between commands
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        seg_len      = SEG_W'((lfsr_q & SEG_MASK) + 16'd1);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d  = 1'b0;
                    tog_cnt_d    = '0;
                    settle_cnt_d = SETTLE_INIT;
                    state_d      = ST_SETTLE;
                    if (cmd_level != button_out_q) begin
                        button_out_d = cmd_level;
                        if (HAS_BOUNCE) begin
                            seg_cnt_d = seg_len;
                            state_d   = ST_BOUNCE;
                        end
                    end
                end
            end
            ST_BOUNCE: begin
                if (seg_cnt_q > SEG_W'(1)) begin
                    seg_cnt_d = seg_cnt_q - SEG_W'(1);
                end else begin
                    // Even toggle count guarantees the line ends at the commanded level
                    button_out_d = ~button_out_q;
                    tog_cnt_d    = tog_cnt_q + TOG_W'(1);
                    if (tog_cnt_d == TOG_TOTAL) begin
                        settle_cnt_d = SETTLE_INIT;
                        state_d      = ST_SETTLE;
                    end else begin
                        seg_cnt_d = seg_len;
                    end
                end
            end
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q - SET_W'(1);
                if (settle_cnt_q == SET_W'(1)) begin
                    settled_d   = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase

        busy_d = ~cmd_ready_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= LFSR_SEED;
            seg_cnt_q    <= '0;
            tog_cnt_q    <= '0;
            settle_cnt_q <= '0;
            button_out_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            settled_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            seg_cnt_q    <= seg_cnt_d;
            tog_cnt_q    <= tog_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            button_out_q <= button_out_d;
            cmd_ready_q  <= cmd_ready_d;
            settled_q    <= settled_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign button_out = button_out_q;
    assign settled    = settled_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Scoreboard bench: instance 0 uses N_BOUNCES=2/MAX_SEG=1/SETTLE=3 for directed cases, instance 1 uses defaults for random traffic.
module tb_button_bounce_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic a_vld, a_lvl, a_rdy, a_btn, a_set, a_busy;
    logic b_vld, b_lvl, b_rdy, b_btn, b_set, b_busy;

    button_bounce_gen #(.N_BOUNCES(2), .MAX_SEG(1), .SETTLE_CYCLES(3), .LFSR_SEED(16'hACE1)) u_a (
        .clk(clk), .reset(reset), .cmd_valid(a_vld), .cmd_level(a_lvl),
        .cmd_ready(a_rdy), .button_out(a_btn), .settled(a_set), .busy(a_busy)
    );

    button_bounce_gen u_b (
        .clk(clk), .reset(reset), .cmd_valid(b_vld), .cmd_level(b_lvl),
        .cmd_ready(b_rdy), .button_out(b_btn), .settled(b_set), .busy(b_busy)
    );

    typedef struct {
        int   cyc;
        logic kind;   // 0 = button edge, 1 = settled pulse
        logic lvl;
        int   ntog;
    } ev_t;

    ev_t         q[2][$];
    int          edge_n = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic        rst_at_edge = 1'b0;
    logic        m_btn[2] = '{1'b0, 1'b0};
    logic        prev[2] = '{1'b0, 1'b0};
    int          tog[2] = '{0, 0};
    int          last_edge[2] = '{0, 0};
    int          errors = 0;
    int          checks = 0;

    // Simple debouncer standing in for push_button: LED follows a level stable for 10 cycles
    logic led = 1'b0;
    int   db_cnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            led = 1'b0;
            db_cnt = 0;
        end else if (b_btn != led) begin
            db_cnt++;
            if (db_cnt >= 10) begin
                led = b_btn;
                db_cnt = 0;
            end
        end else begin
            db_cnt = 0;
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    always @(posedge clk) begin
        edge_n++;
        rst_at_edge = reset;
        m_lfsr = reset ? 16'hACE1 : lfsr_step(m_lfsr);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Expected waveform for a command accepted at edge k, from segment lengths (lfsr mod MAX_SEG)+1
    task automatic expect_cmd(input int i, input int k, input logic lvl);
        int nb, ms, st, t, len, nt;
        logic [15:0] v;
        logic cur;
        nb = (i == 0) ? 2 : 4;
        ms = (i == 0) ? 1 : 8;
        st = (i == 0) ? 3 : 16;
        t  = k;
        v  = m_lfsr;
        nt = 0;
        if (lvl != m_btn[i]) begin
            q[i].push_back('{cyc: k, kind: 1'b0, lvl: lvl, ntog: 0});
            cur = lvl;
            nt  = 1;
            for (int j = 0; j < 2 * nb; j++) begin
                len = (int'(v) % ms) + 1;
                for (int s = 0; s < len; s++) v = lfsr_step(v);
                t  += len;
                cur = ~cur;
                nt++;
                q[i].push_back('{cyc: t, kind: 1'b0, lvl: cur, ntog: 0});
            end
        end
        q[i].push_back('{cyc: t + st, kind: 1'b1, lvl: lvl, ntog: nt});
        m_btn[i] = lvl;
    endtask

    task automatic mon(input int i, input logic btn, input logic set, input logic rdy,
                       input logic bsy, input logic ld);
        if (rst_at_edge) begin
            q[i].delete();
            m_btn[i] = 1'b0;
            tog[i] = 0;
            chk("reset_button", int'(btn), 0);
            chk("reset_ready", int'(rdy), 1);
            chk("reset_settled", int'(set), 0);
        end else begin
            while (q[i].size() > 0 && q[i][0].cyc < edge_n) begin
                chk("missed_event_cycle", edge_n, q[i][0].cyc);
                void'(q[i].pop_front());
            end
            if (btn != prev[i]) begin
                tog[i]++;
                if (q[i].size() == 0 || q[i][0].kind) begin
                    chk("unexpected_toggle", 1, 0);
                end else begin
                    chk("edge_cycle", edge_n, q[i][0].cyc);
                    chk("edge_level", int'(btn), int'(q[i][0].lvl));
                    if (i == 1 && tog[i] > 1)
                        chk("seg_in_range", int'((edge_n - last_edge[i]) >= 1 && (edge_n - last_edge[i]) <= 8), 1);
                    void'(q[i].pop_front());
                end
                last_edge[i] = edge_n;
            end
            if (set) begin
                if (q[i].size() == 0 || !q[i][0].kind) begin
                    chk("unexpected_settled", 1, 0);
                end else begin
                    chk("settled_cycle", edge_n, q[i][0].cyc);
                    chk("toggle_count", tog[i], q[i][0].ntog);
                    chk("settled_level", int'(btn), int'(q[i][0].lvl));
                    if (i == 1) chk("led_level", int'(ld), int'(q[i][0].lvl));
                    void'(q[i].pop_front());
                end
                tog[i] = 0;
            end
            chk("ready_vs_pending", int'(rdy), int'(q[i].size() == 0));
            chk("busy_vs_ready", int'(bsy), int'(!rdy));
        end
        prev[i] = btn;
    endtask

    always @(negedge clk) begin
        mon(0, a_btn, a_set, a_rdy, a_busy, 1'b0);
        mon(1, b_btn, b_set, b_rdy, b_busy, led);
    end

    task automatic drive(input int i, input logic v, input logic l);
        if (i == 0) begin a_vld = v; a_lvl = l; end
        else        begin b_vld = v; b_lvl = l; end
    endtask

    function automatic logic rdy_of(input int i);
        return (i == 0) ? a_rdy : b_rdy;
    endfunction

    // Call at negedge+1; holds cmd_valid until accepted
    task automatic send(input int i, input logic lvl);
        int n = 0;
        drive(i, 1'b1, lvl);
        while (!rdy_of(i) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!rdy_of(i)) begin
            errors++;
            $display("FAIL accept_timeout: inst %0d never ready, required ready within 300 cycles", i);
            drive(i, 1'b0, 1'b0);
        end else begin
            expect_cmd(i, edge_n + 1, lvl);
            @(posedge clk); #1;
            drive(i, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (q[i].size() > 0 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (q[i].size() > 0) begin
            errors++;
            $display("FAIL idle_timeout: inst %0d has %0d pending events, required 0", i, q[i].size());
        end
    endtask

    initial begin
        logic lvl;
        int   n;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Same-level command right after reset: no toggles, settled after SETTLE_CYCLES
        @(negedge clk); #1;
        send(0, 1'b0);
        wait_idle(0);

        // Press, then release issued in the settled cycle
        @(negedge clk); #1;
        send(0, 1'b1);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!a_set && n < 100);
        chk("settled_seen", int'(a_set), 1);
        send(0, 1'b0);
        wait_idle(0);

        // Press with extra requests while busy; they must be dropped
        @(negedge clk); #1;
        send(0, 1'b1);
        @(negedge clk); #1;
        drive(0, 1'b1, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        drive(0, 1'b0, 1'b0);
        wait_idle(0);

        // Reset during bounce, then a fresh press
        @(negedge clk); #1;
        send(0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        send(0, 1'b1);
        wait_idle(0);

        // Random press/release traffic on the default instance
        for (int c = 0; c < 50; c++) begin
            lvl = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            send(1, lvl);
            if ($urandom_range(0, 3) != 0) wait_idle(1);
        end
        wait_idle(1);
        wait_idle(0);
        repeat (4) @(negedge clk);

        chk("queue0_drained", q[0].size(), 0);
        chk("queue1_drained", q[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
